// File: rtl/busca_binaria_sar_if.sv
// Handshake and comparator bundle for busca_binaria_sar.
// master: requester plus comparator model. slave: the search engine.
interface busca_binaria_sar_if #(
    parameter int WIDTH = 4
);
    localparam int CNT_W = $clog2(WIDTH + 2);

    logic             inicio;
    logic             Igual;
    logic             Menor;
    logic             Maior;
    logic [WIDTH-1:0] Palpite;
    logic [WIDTH-1:0] Resultado;
    logic             ocupado;
    logic             pronto;
    logic             erro;
    logic [CNT_W-1:0] Tentativas;

    modport master (
        output inicio, Igual, Menor, Maior,
        input  Palpite, Resultado, ocupado, pronto, erro, Tentativas
    );

    modport slave (
        input  inicio, Igual, Menor, Maior,
        output Palpite, Resultado, ocupado, pronto, erro, Tentativas
    );
endinterface

// File: rtl/busca_binaria_sar.sv
// Successive-approximation search that drives a comparator's guess and converges on its hidden target.
// Optional macro CONFIRMA_EN adds a final verification compare of the bit-0-cleared candidate.
//
// state    | meaning
// OCIOSO   | idle, waiting for inicio; outputs of last search held
// TESTE    | one guess per cycle, refine bit k from comparator flags
// CONFIRMA | (CONFIRMA_EN only) verify the candidate chosen at k==0
// FIM      | pronto pulse, then back to OCIOSO
module busca_binaria_sar #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    busca_binaria_sar_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 2);
    localparam int KW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB = ONE << (WIDTH - 1);

`ifdef CONFIRMA_EN
    typedef enum logic [1:0] {OCIOSO, TESTE, CONFIRMA, FIM} state_t;
`else
    typedef enum logic [1:0] {OCIOSO, TESTE, FIM} state_t;
`endif

    state_t           state;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] palpite_q;
    logic [WIDTH-1:0] resultado_q;
    logic             ocupado_q;
    logic             pronto_q;
    logic             erro_q;
    logic [CNT_W-1:0] tent_q;

    logic [WIDTH-1:0] bit_k;
    logic [WIDTH-1:0] bit_km1;
    logic             flags_ok;

    assign bit_k   = ONE << k;
    assign bit_km1 = ONE << (k - KW'(1));

    always_comb begin
        flags_ok = 1'b0;
        case ({bus.Igual, bus.Menor, bus.Maior})
            3'b100, 3'b010, 3'b001: flags_ok = 1'b1;
            default:                flags_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= OCIOSO;
            k           <= '0;
            palpite_q   <= '0;
            resultado_q <= '0;
            ocupado_q   <= 1'b0;
            pronto_q    <= 1'b0;
            erro_q      <= 1'b0;
            tent_q      <= '0;
        end else begin
            pronto_q <= 1'b0;
            case (state)
                OCIOSO: begin
                    if (bus.inicio) begin
                        state       <= TESTE;
                        palpite_q   <= MSB;
                        k           <= KW'(WIDTH - 1);
                        resultado_q <= '0;
                        erro_q      <= 1'b0;
                        tent_q      <= '0;
                        ocupado_q   <= 1'b1;
                    end
                end
                TESTE: begin
                    tent_q <= tent_q + 1'b1;
                    if (!flags_ok) begin
                        erro_q    <= 1'b1;
                        state     <= FIM;
                        ocupado_q <= 1'b0;
                        pronto_q  <= 1'b1;
                    end else if (bus.Igual) begin
                        resultado_q <= palpite_q;
                        state       <= FIM;
                        ocupado_q   <= 1'b0;
                        pronto_q    <= 1'b1;
                    end else if (k != '0) begin
                        // Maior keeps bit k, Menor drops it; either way try bit k-1 next
                        if (bus.Maior)
                            palpite_q <= palpite_q | bit_km1;
                        else
                            palpite_q <= (palpite_q & ~bit_k) | bit_km1;
                        k <= k - KW'(1);
                    end else if (bus.Maior) begin
                        erro_q      <= 1'b1;
                        resultado_q <= palpite_q;
                        state       <= FIM;
                        ocupado_q   <= 1'b0;
                        pronto_q    <= 1'b1;
                    end else begin
`ifdef CONFIRMA_EN
                        palpite_q <= palpite_q & ~ONE;
                        state     <= CONFIRMA;
`else
                        resultado_q <= palpite_q & ~ONE;
                        state       <= FIM;
                        ocupado_q   <= 1'b0;
                        pronto_q    <= 1'b1;
`endif
                    end
                end
`ifdef CONFIRMA_EN
                CONFIRMA: begin
                    tent_q      <= tent_q + 1'b1;
                    resultado_q <= palpite_q;
                    if (!(flags_ok && bus.Igual))
                        erro_q <= 1'b1;
                    state     <= FIM;
                    ocupado_q <= 1'b0;
                    pronto_q  <= 1'b1;
                end
`endif
                FIM: begin
                    state <= OCIOSO;
                end
                default: begin
                    state     <= OCIOSO;
                    ocupado_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Palpite    = palpite_q;
    assign bus.Resultado  = resultado_q;
    assign bus.ocupado    = ocupado_q;
    assign bus.pronto     = pronto_q;
    assign bus.erro       = erro_q;
    assign bus.Tentativas = tent_q;
endmodule

// File: tb/tb_busca_binaria_sar.sv
// Directed bench for busca_binaria_sar: comparator model against target A, table of searches
// plus hand sequences for reset and idle behaviour.
module tb_busca_binaria_sar;
    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [WIDTH-1:0] target = '0;
    int mode = 0;   // 0 honest comparator, 1 all flags low, 2 Maior always

    int n_cmp = 0;
    int n_bad = 0;

    busca_binaria_sar_if #(.WIDTH(WIDTH)) bus ();

    busca_binaria_sar #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.Igual = (mode == 0) && (bus.Palpite == target);
    assign bus.Menor = (mode == 0) && (target < bus.Palpite);
    assign bus.Maior = (mode == 2) || ((mode == 0) && (target > bus.Palpite));

    typedef struct {
        logic [3:0]       target;
        int               mode;
        bit               hold;
        logic [3:0]       res;
        int               tent;
        logic             erro;
        logic [4:0][3:0]  g;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [4:0][3:0] seq(input logic [3:0] a, input logic [3:0] b,
                                           input logic [3:0] c, input logic [3:0] d,
                                           input logic [3:0] e);
        return {e, d, c, b, a};
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, wanted %0d", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cyc;
        target = v.target;
        mode   = v.mode;
        @(negedge clk);
        bus.inicio = 1'b1;
        @(negedge clk);
        if (!v.hold) bus.inicio = 1'b0;
        check($sformatf("v%0d ocupado_first", idx), int'(bus.ocupado), 1);
        check($sformatf("v%0d resultado_cleared", idx), int'(bus.Resultado), 0);
        check($sformatf("v%0d tent_cleared", idx), int'(bus.Tentativas), 0);
        check($sformatf("v%0d erro_cleared", idx), int'(bus.erro), 0);
        cyc = 0;
        while (!bus.pronto && cyc < 12) begin
            if (cyc < v.tent)
                check($sformatf("v%0d guess%0d", idx, cyc), int'(bus.Palpite), int'(v.g[cyc]));
            cyc++;
            @(negedge clk);
        end
        check($sformatf("v%0d pronto_seen", idx), int'(bus.pronto), 1);
        check($sformatf("v%0d latency", idx), cyc, v.tent);
        check($sformatf("v%0d resultado", idx), int'(bus.Resultado), int'(v.res));
        check($sformatf("v%0d tentativas", idx), int'(bus.Tentativas), v.tent);
        check($sformatf("v%0d erro", idx), int'(bus.erro), int'(v.erro));
        check($sformatf("v%0d ocupado_fim", idx), int'(bus.ocupado), 0);
        bus.inicio = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d pronto_pulse", idx), int'(bus.pronto), 0);
        check($sformatf("v%0d resultado_held", idx), int'(bus.Resultado), int'(v.res));
        check($sformatf("v%0d erro_held", idx), int'(bus.erro), int'(v.erro));
        @(negedge clk);
        check($sformatf("v%0d stays_idle", idx), int'(bus.ocupado), 0);
    endtask

    initial begin
        bus.inicio = 1'b0;

        vecs[0] = '{4'b1010, 0, 1'b0, 4'b1010, 3, 1'b0, seq(4'b1000, 4'b1100, 4'b1010, 4'h0, 4'h0)};
        vecs[1] = '{4'b1111, 0, 1'b0, 4'b1111, 4, 1'b0, seq(4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'h0)};
`ifdef CONFIRMA_EN
        vecs[2] = '{4'b0000, 0, 1'b0, 4'b0000, 5, 1'b0, seq(4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000)};
`else
        vecs[2] = '{4'b0000, 0, 1'b0, 4'b0000, 4, 1'b0, seq(4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'h0)};
`endif
        vecs[3] = '{4'b0101, 1, 1'b0, 4'b0000, 1, 1'b1, seq(4'b1000, 4'h0, 4'h0, 4'h0, 4'h0)};
        vecs[4] = '{4'b0011, 2, 1'b0, 4'b1111, 4, 1'b1, seq(4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'h0)};
        vecs[5] = '{4'b0101, 0, 1'b1, 4'b0101, 4, 1'b0, seq(4'b1000, 4'b0100, 4'b0110, 4'b0101, 4'h0)};
        vecs[6] = '{4'b1000, 0, 1'b0, 4'b1000, 1, 1'b0, seq(4'b1000, 4'h0, 4'h0, 4'h0, 4'h0)};
        vecs[7] = '{4'b0111, 0, 1'b0, 4'b0111, 4, 1'b0, seq(4'b1000, 4'b0100, 4'b0110, 4'b0111, 4'h0)};

        #1;
        check("reset_palpite", int'(bus.Palpite), 0);
        check("reset_ocupado", int'(bus.ocupado), 0);
        check("reset_pronto", int'(bus.pronto), 0);
        check("reset_tent", int'(bus.Tentativas), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_no_start", int'(bus.ocupado), 0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // reset in the middle of a search aborts silently
        target = 4'b1111;
        mode   = 0;
        @(negedge clk);
        bus.inicio = 1'b1;
        @(negedge clk);
        bus.inicio = 1'b0;
        @(negedge clk);
        check("mid_ocupado_before", int'(bus.ocupado), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_palpite", int'(bus.Palpite), 0);
        check("mid_rst_ocupado", int'(bus.ocupado), 0);
        check("mid_rst_tent", int'(bus.Tentativas), 0);
        check("mid_rst_resultado", int'(bus.Resultado), 0);
        check("mid_rst_erro", int'(bus.erro), 0);
        check("mid_rst_pronto", int'(bus.pronto), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("post_rst_pronto%0d", c), int'(bus.pronto), 0);
        end
        check("post_rst_ocupado", int'(bus.ocupado), 0);

        // a fresh search after the abort still works
        run_vec(vecs[0], 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
